// File: rtl/isqrt_seq.sv
// isqrt_seq -- sequential integer square root, one result bit per clock.
//
// Takes the signed sum of squares from the square-results adder and returns
// its floor square root (the Euclidean magnitude) and the remainder. The
// digit-by-digit (restoring) method retires two operand bits per clock, so a
// result takes RES_WIDTH clocks after the operand is accepted. A negative
// operand means the adder overflowed upstream. It is flagged on out_err
// without running the iteration.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   in_data valid
//   in_ready   stage can accept an operand (high only in IDLE)
//   in_data    signed two's-complement operand, IN_WIDTH bits
//   out_valid  result valid, held until out_ready
//   out_ready  downstream accepts the result
//   out_root   unsigned root, RES_WIDTH bits
//   out_rem    unsigned remainder in_data - floor_root^2, RES_WIDTH+1 bits
//   out_err    operand was negative
//
// Optional feature macro: ISQRT_ROUND_EN
//   When defined, out_root is rounded to the nearest integer. out_rem still
//   reports the floor remainder.

module isqrt_seq #(
  parameter int IN_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [IN_WIDTH-1:0]     in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [IN_WIDTH/2-1:0]   out_root,
  output logic [IN_WIDTH/2:0]     out_rem,
  output logic                    out_err
);

  localparam int RES_WIDTH = IN_WIDTH / 2;
  localparam int REM_W     = RES_WIDTH + 2;
  localparam int CNT_W     = (RES_WIDTH > 1) ? $clog2(RES_WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [IN_WIDTH-1:0]   op_q, op_d;
  logic [REM_W-1:0]      rem_q, rem_d;
  logic [RES_WIDTH-1:0]  root_q, root_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [RES_WIDTH-1:0]  out_root_q, out_root_d;
  logic [RES_WIDTH:0]    out_rem_q, out_rem_d;
  logic                  out_err_q, out_err_d;
  logic                  out_valid_q, out_valid_d;
  logic                  in_ready_q, in_ready_d;

  // One digit step of the restoring square root.
  logic [REM_W-1:0]      rem_shift;
  logic [REM_W-1:0]      trial;
  logic [REM_W-1:0]      rem_step;
  logic [RES_WIDTH-1:0]  root_step;
  logic [RES_WIDTH-1:0]  final_root;

  always_comb begin
    // Before the final step the partial remainder is at most 2*root, and the
    // partial root is below 2^(RES_WIDTH-1). This means the top two remainder
    // bits and the top root bit are zero, so they can be dropped by the shift.
    rem_shift = {rem_q[REM_W-3:0], op_q[IN_WIDTH-1 -: 2]};
    trial     = {root_q, 2'b01};
    if (rem_shift >= trial) begin
      rem_step  = rem_shift - trial;
      root_step = {root_q[RES_WIDTH-2:0], 1'b1};
    end else begin
      rem_step  = rem_shift;
      root_step = {root_q[RES_WIDTH-2:0], 1'b0};
    end
`ifdef ISQRT_ROUND_EN
    // Round half-up: x >= (r+0.5)^2 holds exactly when rem > r. The signed
    // input keeps the root below 2^(RES_WIDTH-0.5), so r+1 cannot wrap.
    if (rem_step > {2'b00, root_step}) begin
      final_root = root_step + 1'b1;
    end else begin
      final_root = root_step;
    end
`else
    final_root = root_step;
`endif
  end

  // Next-state and next-output logic for the IDLE -> CALC -> DONE sequence.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    rem_d       = rem_q;
    root_d      = root_q;
    cnt_d       = cnt_q;
    out_root_d  = out_root_q;
    out_rem_d   = out_rem_q;
    out_err_d   = out_err_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;

    unique case (state_q)
      IDLE: begin
        in_ready_d = 1'b1;
        if (in_valid && in_ready_q) begin
          in_ready_d = 1'b0;
          if (in_data[IN_WIDTH-1]) begin
            // A negative operand skips the iteration and reports the error.
            state_d     = DONE;
            out_root_d  = '0;
            out_rem_d   = '0;
            out_err_d   = 1'b1;
            out_valid_d = 1'b1;
          end else begin
            state_d = CALC;
            op_d    = in_data;
            rem_d   = '0;
            root_d  = '0;
            cnt_d   = CNT_W'(RES_WIDTH - 1);
          end
        end
      end

      CALC: begin
        in_ready_d = 1'b0;
        op_d       = {op_q[IN_WIDTH-3:0], 2'b00};
        rem_d      = rem_step;
        root_d     = root_step;
        cnt_d      = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          cnt_d       = '0;
          state_d     = DONE;
          out_root_d  = final_root;
          out_rem_d   = rem_step[RES_WIDTH:0];
          out_err_d   = 1'b0;
          out_valid_d = 1'b1;
        end
      end

      DONE: begin
        // Holding here while out_ready is low keeps every output stable.
        // in_ready stays low on the handshake edge, so a new operand can be
        // accepted only on a later edge.
        in_ready_d = 1'b0;
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  // Resetting abandons any operation in flight. No result is presented for it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= '0;
      rem_q       <= '0;
      root_q      <= '0;
      cnt_q       <= '0;
      out_root_q  <= '0;
      out_rem_q   <= '0;
      out_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      rem_q       <= rem_d;
      root_q      <= root_d;
      cnt_q       <= cnt_d;
      out_root_q  <= out_root_d;
      out_rem_q   <= out_rem_d;
      out_err_q   <= out_err_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_root  = out_root_q;
  assign out_rem   = out_rem_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_isqrt_seq.sv
// tb_isqrt_seq -- directed bench for isqrt_seq (IN_WIDTH = 32).
// Expected roots and remainders are hand computed. When ISQRT_ROUND_EN is
// defined, the rounded roots are selected instead of the floor roots.

module tb_isqrt_seq;

  localparam int IN_WIDTH = 32;
  localparam int RES_WIDTH = IN_WIDTH / 2;
`ifdef ISQRT_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  logic                  clk;
  logic                  rst_n;
  logic                  in_valid;
  logic                  in_ready;
  logic [IN_WIDTH-1:0]   in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [RES_WIDTH-1:0]  out_root;
  logic [RES_WIDTH:0]    out_rem;
  logic                  out_err;

  int vectors;
  int miscompares;

  isqrt_seq #(.IN_WIDTH(IN_WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_root  (out_root),
    .out_rem   (out_rem),
    .out_err   (out_err)
  );

  // 10 ns clock; outputs are sampled on the falling edge.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every vector and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Wait (bounded) for out_valid after the accepting edge; lat = edge index.
  task automatic waitResult(input string tag, output int lat);
    lat = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = k;
        break;
      end
      @(posedge clk);
    end
    if (lat < 0) checkOutput({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  // Present one operand once in_ready is high, then release the bus.
  task automatic applyStimulus(input string tag, input logic [31:0] data,
                               output int lat);
    bit got_ready;
    got_ready = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready) begin
        got_ready = 1'b1;
        break;
      end
    end
    if (!got_ready) checkOutput({tag, "_ready_timeout"}, 64'd0, 64'd1);
    in_valid = 1'b1;
    in_data  = data;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 32'hDEAD_BEEF;
    waitResult(tag, lat);
  endtask

  task automatic checkResult(input string tag, input int lat, input int exp_lat,
                             input logic [63:0] root_floor,
                             input logic [63:0] root_round,
                             input logic [63:0] rem, input logic err);
    checkOutput({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    checkOutput({tag, "_root"}, 64'(out_root), ROUND ? root_round : root_floor);
    checkOutput({tag, "_rem"}, 64'(out_rem), rem);
    checkOutput({tag, "_err"}, 64'(out_err), 64'(err));
    checkOutput({tag, "_in_ready"}, 64'(in_ready), 64'd0);
  endtask

  // One output handshake, then confirm that out_valid dropped and in_ready rose.
  task automatic doHandshake(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    checkOutput({tag, "_valid_after_hs"}, 64'(out_valid), 64'd0);
    checkOutput({tag, "_ready_after_hs"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    int lat;
    int stale;
    logic [63:0] held;

    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    out_ready   = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_outputs", {out_err, out_root, out_rem}, 64'd0);
    rst_n = 1'b1;

    // Reset in the middle of CALC: the result for 1000 must never appear.
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 32'd1000;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("midrst_outputs", {out_valid, out_err, out_root, out_rem}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    checkOutput("midrst_no_stale", 64'(stale), 64'd0);

    // Zero operand
    applyStimulus("zero", 32'd0, lat);
    checkResult("zero", lat, 16, 0, 0, 0, 1'b0);
    doHandshake("zero");

    // One, the smallest nonzero operand
    applyStimulus("one", 32'd1, lat);
    checkResult("one", lat, 16, 1, 1, 0, 1'b0);
    doHandshake("one");

    // Largest perfect square that fits
    applyStimulus("sq_max", 32'd2147395600, lat);
    checkResult("sq_max", lat, 16, 46340, 46340, 0, 1'b0);
    doHandshake("sq_max");

    // Largest positive operand
    applyStimulus("pos_max", 32'd2147483647, lat);
    checkResult("pos_max", lat, 16, 46340, 46341, 88047, 1'b0);
    doHandshake("pos_max");

    // Negative operand: error flag right after the accepting edge
    applyStimulus("neg5", 32'hFFFF_FFFB, lat);
    checkResult("neg5", lat, 0, 0, 0, 0, 1'b1);
    doHandshake("neg5");

    // Backpressure on the result for 15, with 24 waiting on the input
    applyStimulus("bp15", 32'd15, lat);
    checkResult("bp15", lat, 16, 3, 4, 6, 1'b0);
    held     = {out_valid, out_err, out_root, out_rem};
    in_valid = 1'b1;
    in_data  = 32'd24;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checkOutput("bp_hold", {out_valid, out_err, out_root, out_rem}, held);
      checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    checkOutput("bp_valid_after_hs", 64'(out_valid), 64'd0);
    checkOutput("bp_ready_after_hs", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 32'h1234_5678;
    waitResult("bp24", lat);
    checkResult("bp24", lat, 16, 4, 5, 8, 1'b0);
    doHandshake("bp24");

    // Back-to-back operands with out_ready held high
    out_ready = 1'b1;
    applyStimulus("b2b100", 32'd100, lat);
    checkResult("b2b100", lat, 16, 10, 10, 0, 1'b0);
    applyStimulus("b2b99", 32'd99, lat);
    checkResult("b2b99", lat, 16, 9, 10, 18, 1'b0);
    applyStimulus("b2b65536", 32'd65536, lat);
    checkResult("b2b65536", lat, 16, 256, 256, 0, 1'b0);
    @(negedge clk);
    checkOutput("b2b_drained", 64'(out_valid), 64'd0);
    out_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
